// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: decoded instruction payload and the
// decode/execute handoff controller state encoding.
package riscv_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
    } decoded_instr_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        BUBBLE = 2'd2
    } de_ctrl_state_t;

    localparam logic [4:0]  REG_ZERO     = 5'd0;
    localparam logic [31:0] PERF_CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic src_match(input logic use_src,
                                       input logic [4:0] rs,
                                       input logic [4:0] rd);
        return use_src && (rs == rd);
    endfunction

endpackage

// File: rtl/lu_hazard_detect.sv
// Combinational load-use hazard check between the held instruction in the
// decode/execute register and the instruction currently offered by decode.
module lu_hazard_detect
    import riscv_pkg::*;
(
    input  logic       held_valid,
    input  logic       held_is_load,
    input  logic [4:0] held_rd,
    input  logic       dec_valid,
    input  logic       dec_use_rs1,
    input  logic [4:0] dec_rs1,
    input  logic       dec_use_rs2,
    input  logic [4:0] dec_rs2,
    output logic       hazard
);

    // x0 never carries a real dependency, so a load to x0 cannot stall.
    always_comb begin
        hazard = held_valid && held_is_load && (held_rd != REG_ZERO) && dec_valid &&
                 (src_match(dec_use_rs1, dec_rs1, held_rd) ||
                  src_match(dec_use_rs2, dec_rs2, held_rd));
    end

endmodule

// File: rtl/de_stage_ctrl.sv
// Decode-to-execute handoff controller with load-use bubble insertion and flush.
// Optional performance counters enabled by defining DE_STAGE_CTRL_PERF_EN.
module de_stage_ctrl
    import riscv_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           dec_valid,
    output logic           dec_ready,
    input  decoded_instr_t dec_instr,
    input  logic [4:0]     dec_rs1,
    input  logic [4:0]     dec_rs2,
    input  logic           dec_use_rs1,
    input  logic           dec_use_rs2,
    input  logic [4:0]     dec_rd,
    input  logic           dec_is_load,
    output logic           ex_valid,
    input  logic           ex_ready,
    output decoded_instr_t ex_instr,
    input  logic           flush,
    output logic           lu_stall
`ifdef DE_STAGE_CTRL_PERF_EN
    ,
    output logic [31:0]    perf_stall_cnt,
    output logic [31:0]    perf_flush_cnt
`endif
);

    de_ctrl_state_t state_r;
    de_ctrl_state_t state_next_s;
    decoded_instr_t ex_instr_r;
    logic [4:0]     held_rd_r;
    logic           held_is_load_r;
    logic           hazard_s;
    logic           capture_s;
    logic           dec_ready_s;

    lu_hazard_detect u_lu_hazard_detect (
        .held_valid   (state_r == FULL),
        .held_is_load (held_is_load_r),
        .held_rd      (held_rd_r),
        .dec_valid    (dec_valid),
        .dec_use_rs1  (dec_use_rs1),
        .dec_rs1      (dec_rs1),
        .dec_use_rs2  (dec_use_rs2),
        .dec_rs2      (dec_rs2),
        .hazard       (hazard_s)
    );

    // Next-state and handshake decode; flush overrides every transition.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        dec_ready_s  = 1'b0;
        case (state_r)
            EMPTY: begin
                dec_ready_s = 1'b1;
                if (dec_valid) begin
                    state_next_s = FULL;
                    capture_s    = 1'b1;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            FULL: begin
                dec_ready_s = ex_ready && !hazard_s;
                if (!ex_ready) begin
                    state_next_s = FULL;
                end else if (hazard_s) begin
                    state_next_s = BUBBLE;
                end else if (dec_valid) begin
                    state_next_s = FULL;
                    capture_s    = 1'b1;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            BUBBLE: begin
                dec_ready_s = 1'b1;
                if (dec_valid) begin
                    state_next_s = FULL;
                    capture_s    = 1'b1;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            default: begin
                state_next_s = EMPTY;
            end
        endcase
        if (flush) begin
            state_next_s = EMPTY;
            capture_s    = 1'b0;
            dec_ready_s  = 1'b0;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State register and held-instruction capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= EMPTY;
            ex_instr_r     <= '0;
            held_rd_r      <= 5'd0;
            held_is_load_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (capture_s) begin
                ex_instr_r     <= dec_instr;
                held_rd_r      <= dec_rd;
                held_is_load_r <= dec_is_load;
            end
        end
    end

    assign dec_ready = dec_ready_s;
    assign ex_valid  = (state_r == FULL);
    assign ex_instr  = ex_instr_r;
    assign lu_stall  = hazard_s;

`ifdef DE_STAGE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt_r;
    logic [31:0] perf_flush_cnt_r;

    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_r <= 32'd0;
            perf_flush_cnt_r <= 32'd0;
        end else begin
            if (hazard_s && (perf_stall_cnt_r != PERF_CNT_MAX)) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
            end
            if (flush && (perf_flush_cnt_r != PERF_CNT_MAX)) begin
                perf_flush_cnt_r <= perf_flush_cnt_r + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_r;
    assign perf_flush_cnt = perf_flush_cnt_r;
`endif

endmodule

// File: doc/de_stage_ctrl.md
DE_STAGE_CTRL -- requirements
Module: de_stage_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  shared pipeline clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 dec_valid  in  1  decode stage presents an instruction.
REQ-005 dec_ready  out  1  controller accepts the decode instruction this cycle.
REQ-006 dec_instr  in  decoded_instr_t  decoded instruction payload (riscv_pkg).
REQ-007 dec_rs1, dec_rs2  in  5 each  source register indices.
REQ-008 dec_use_rs1, dec_use_rs2  in  1 each  source actually read.
REQ-009 dec_rd  in  5  destination register index.
REQ-010 dec_is_load  in  1  instruction is a load.
REQ-011 ex_valid  out  1  held instruction valid to execute.
REQ-012 ex_ready  in  1  execute accepts the held instruction this cycle.
REQ-013 ex_instr  out  decoded_instr_t  held instruction payload.
REQ-014 flush  in  1  execute redirect (taken branch/jump); kills held and incoming instruction.
REQ-015 lu_stall  out  1  load-use hazard detected this cycle (combinational).

Function
REQ-016 SHALL implement FSM states EMPTY, FULL, BUBBLE; ex_valid = (state == FULL).
REQ-017 hazard = FULL && held_is_load && held_rd != 0 && dec_valid && ((dec_use_rs1 && dec_rs1 == held_rd) || (dec_use_rs2 && dec_rs2 == held_rd)); lu_stall = hazard.
REQ-018 dec_ready = !flush && (EMPTY || BUBBLE || (FULL && ex_ready && !hazard)).
REQ-019 Capture: when dec_valid && dec_ready, register dec_instr, dec_rd, dec_is_load.
REQ-020 flush SHALL force next state EMPTY, overriding every other condition; no capture that cycle.
REQ-021 EMPTY: dec_valid -> FULL with capture; else stay EMPTY.
REQ-022 FULL, ex_ready=0: stay FULL; ex_instr and held fields stable.
REQ-023 FULL, ex_ready=1: hazard -> BUBBLE (no capture); else dec_valid -> FULL with capture (back-to-back, no gap); else -> EMPTY.
REQ-024 BUBBLE SHALL last one cycle with ex_valid=0: dec_valid -> FULL with capture; else -> EMPTY.
REQ-025 Latency: an instruction accepted in cycle N SHALL appear with ex_valid=1 in cycle N+1.
REQ-026 Throughput: one instruction per cycle absent hazards, flushes and execute backpressure.
REQ-027 ex_instr SHALL change only on capture; its value in EMPTY/BUBBLE is don't-care.

Reset
REQ-028 rst SHALL set state EMPTY, ex_valid=0, held_is_load=0, held_rd=0, and clear performance counters; dec_ready=1 in the first cycle after reset when flush=0.
REQ-029 rst asserted mid-transfer SHALL drop the held instruction without a handshake; rst has priority over flush.

Configuration
REQ-030 Macro DE_STAGE_CTRL_PERF_EN defined: adds outputs perf_stall_cnt[31:0] (+1 per cycle with lu_stall=1) and perf_flush_cnt[31:0] (+1 per cycle with flush=1); both saturate at 0xFFFFFFFF.
REQ-031 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-032 decoded_instr_t SHALL stay in riscv_pkg; the state enum de_ctrl_state_t (EMPTY, FULL, BUBBLE) SHALL be added to riscv_pkg.
REQ-033 The hazard comparison SHALL be a combinational sub-module lu_hazard_detect; the FSM and register stay in de_stage_ctrl.

Verification
REQ-034 Stream 4 non-load instrs with dec_valid=1, ex_ready=1 -> ex_valid=1 cycles 1..4 after the first accept, ex_instr in order, no gaps.
REQ-035 Held load rd=5, next instr rs1=5 use_rs1=1, ex_ready=1 -> lu_stall=1, dec_ready=0, one cycle ex_valid=0, then dependent instr issued.
REQ-036 Held load rd=0, next rs1=0 -> no stall, back-to-back issue.
REQ-037 FULL with ex_ready=0 for 3 cycles -> ex_instr stable, dec_ready=0; ex_ready=1 then releases in order.
REQ-038 flush=1 while FULL and dec_valid=1 -> next cycle EMPTY, ex_valid=0, no capture; rst=1 while FULL -> ex_valid=0 next cycle.
REQ-039 With DE_STAGE_CTRL_PERF_EN: 2 load-use stalls and 1 flush -> perf_stall_cnt=2, perf_flush_cnt=1.
